out_port_uart_tx: RTL and testbench
===================================

Name: out_port_uart_tx

Overview:
Consumer end of the CPU core's 8-bit output port. It captures bytes written to out_port into a small FIFO and serialises them as 8N1 UART on the Tang Nano 9K TX pin, so firmware output reaches a host terminal. The block sits beside the core in the board top level and is clocked from the same 27 MHz clock.

Parameters:
CLK_HZ, 27000000, input clock frequency in Hz.
BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (default 234). Must be >= 2.
FIFO_DEPTH, 4, FIFO entries. Power of 2, >= 2.

Ports:
clk        input   1  system clock, all logic on rising edge
rst_n      input   1  asynchronous, active-low reset
port_data  input   8  byte from the core's out_port
port_wr    input   1  write strobe, one byte per high cycle (ignored when CHANGE_DETECT_EN is defined)
tx         output  1  UART serial out, idle high
busy       output  1  high when FSM is not IDLE or FIFO is non-empty
fifo_full  output  1  high when FIFO count == FIFO_DEPTH
overflow   output  1  sticky; set when a write is dropped; cleared only by reset

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, fifo_full=0, overflow=0, FIFO count=0, pointers=0, FSM=IDLE, baud counter=0, bit index=0. Reset mid-frame abandons the frame, drives tx=1 immediately and flushes the FIFO.
- FIFO write: port_wr sampled high at an edge with fifo_full=0 stores port_data. If fifo_full=1 at that edge, the byte is dropped and overflow is set. A pop in the same cycle does not rescue it; full is evaluated before the pop.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter and enter START. tx goes to 0 on that same edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7, enter STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Latency: port_wr high at edge k into an empty, idle block gives tx=0 after edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx is driven from a register, never glitches, and has no combinational path from inputs.
- busy falls on the edge STOP→IDLE when the FIFO is empty.

Optional Feature:
Macro: CHANGE_DETECT_EN.
- Defined: a register prev_data (reset 0x00) tracks port_data every cycle. A write is generated in any cycle where port_data != prev_data, and port_wr is ignored. Same full/overflow rules apply.
- Not defined: only port_wr generates writes, and no prev_data register exists.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release with port_wr=0 -> tx=1, busy=0, fifo_full=0, overflow=0 indefinitely.
2. CLK_HZ=1000, BAUD=100, single port_wr with 0xA5 -> tx sequence, each level held 10 cycles: 0, 1,0,1,0,0,1,0,1, 1. busy deasserts exactly 100 cycles after tx falls.
3. CLK_HZ=1000, BAUD=100, port_wr on 6 consecutive cycles with data 0x10..0x15:
   - 0x10..0x14 are transmitted in order as 5 contiguous frames with no idle cycle between them (500 cycles).
   - 0x15 is dropped and overflow=1 stays set.
   - fifo_full is high after the 5th write.
4. Assert rst_n=0 during DATA bit 3 of frame 0x5A with 2 bytes queued -> tx=1 immediately. After release: busy=0, FIFO empty, no further frames.
5. CHANGE_DETECT_EN defined: after reset drive port_data=0x3C and hold 300 cycles -> exactly one 0x3C frame. Then 0x3C→0x00 -> exactly one 0x00 frame. port_wr pulses have no effect.
6. Default parameters, one byte 0xFF -> start bit low for exactly 234 cycles, total frame 2340 cycles.

Source files
------------

// File: rtl/out_port_uart_tx.sv
// Purpose: buffers bytes from the core's out_port in a small FIFO and sends them as 8N1 UART on tx.
// Latency: write at edge k into an empty idle block -> start bit on tx after edge k+1; queued frames go back-to-back.
// Backpressure: none upstream; a write into a full FIFO is dropped and sets sticky overflow. CHANGE_DETECT_EN: writes come from port_data changes.
module out_port_uart_tx #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_data,
  input  logic       port_wr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------
  // Write request generation
  // ---------------------------------------------------------------
  logic wr_req;

`ifdef CHANGE_DETECT_EN
  logic [7:0] prev_data;
  logic       unused_port_wr;
  assign unused_port_wr = port_wr;

  // Track the previous port value; any difference is treated as a new write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_data <= 8'h00;
    else        prev_data <= port_data;
  end

  assign wr_req = (port_data != prev_data);
`else
  assign wr_req = port_wr;
`endif

  // ---------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  // Fullness is judged on the registered count, so a same-cycle pop cannot make room.
  assign push       = wr_req && !fifo_full;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= port_data;
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (wr_req && fifo_full) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_d;
  logic [7:0]       shift;
  logic [7:0]       shift_d;
  logic             tx_q;
  logic             tx_d;
  logic             bit_end;

  assign bit_end = (cnt == '0);

  // State and datapath registers; tx is registered so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: STOP chains straight into START when more bytes are waiting.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pop on frame start, reload the baud counter per bit, and pre-compute the next tx level.
  always_comb begin
    pop     = 1'b0;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = 1'b1;

    if (state_d == START && (state == IDLE || state == STOP)) begin
      pop     = 1'b1;
      shift_d = mem[rd_ptr];
    end else if (state == DATA && bit_end) begin
      shift_d = shift >> 1;
    end

    if (state == START && bit_end)     bit_d = 3'd0;
    else if (state == DATA && bit_end) bit_d = bit_idx + 3'd1;

    if (state_d != IDLE && (state_d != state || bit_end)) cnt_d = BIT_LAST;
    else if (cnt != '0)                                   cnt_d = cnt - CNT_W'(1);

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_out_port_uart_tx.sv
`timescale 1ns/1ps
module tb_out_port_uart_tx;

  localparam int CPB     = 10;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CPB;
  localparam int DEF_CPB = 27000000 / 115200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] port_data = 8'h00;
  logic       port_wr = 1'b0;
  logic       tx, busy, fifo_full, overflow;
  logic [7:0] d_data = 8'h00;
  logic       d_wr = 1'b0;
  logic       d_tx, d_busy, d_full, d_ovf;

  int checks = 0;
  int failures = 0;

  // per-cycle stimulus schedule, model expectations and observed outputs
  logic [7:0] s_dat[$];
  logic       s_wr[$];
  logic       exp_tx[$], exp_busy[$], exp_full[$], exp_ovf[$];
  logic       obs_tx[$], obs_busy[$], obs_full[$], obs_ovf[$];
  logic [7:0] mdl_b[$];
  int         mdl_s[$];
  logic [7:0] dec_b[$];
  int         dec_s[$];

  always #5 clk = ~clk;

  out_port_uart_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .port_data(port_data), .port_wr(port_wr),
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  out_port_uart_tx dut_def (
    .clk(clk), .rst_n(rst_n), .port_data(d_data), .port_wr(d_wr),
    .tx(d_tx), .busy(d_busy), .fifo_full(d_full), .overflow(d_ovf)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete within 2ms");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    port_wr = 1'b0; port_data = 8'h00; d_wr = 1'b0; d_data = 8'h00;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic sched_idle(input int n, input logic [7:0] hold);
    s_dat.delete(); s_wr.delete();
    for (int i = 0; i < n; i++) begin
      s_dat.push_back(hold);
      s_wr.push_back(1'b0);
    end
  endtask

  // write strobe at cycle c; the data value stays on the port afterwards
  task automatic sched_write(input int c, input logic [7:0] d);
    s_wr[c] = 1'b1;
    for (int i = c; i < s_dat.size(); i++) s_dat[i] = d;
  endtask

  // Reference: a byte queue and the time the line becomes free; each frame is
  // start bit, 8 data bits LSB first, stop bit, CPB cycles each.
  task automatic build_model(input int n);
    logic [7:0] q[$];
    int         free;
    logic       ovf, full, wr, txv;
    logic [7:0] prev;
    int         k;
    free = 0; ovf = 1'b0; prev = 8'h00;
    q.delete(); mdl_b.delete(); mdl_s.delete();
    exp_tx.delete(); exp_busy.delete(); exp_full.delete(); exp_ovf.delete();
    for (int t = 0; t < n; t++) begin
      full = (q.size() == DEPTH);
`ifdef CHANGE_DETECT_EN
      wr = (s_dat[t] != prev);
`else
      wr = s_wr[t];
`endif
      prev = s_dat[t];
      if (q.size() > 0 && t >= free) begin
        mdl_s.push_back(t);
        mdl_b.push_back(q.pop_front());
        free = t + FRAME;
      end
      if (wr) begin
        if (full) ovf = 1'b1;
        else      q.push_back(s_dat[t]);
      end
      txv = 1'b1;
      for (int i = 0; i < mdl_s.size(); i++) begin
        if (t >= mdl_s[i] && t < mdl_s[i] + FRAME) begin
          k = (t - mdl_s[i]) / CPB;
          if (k == 0)      txv = 1'b0;
          else if (k == 9) txv = 1'b1;
          else             txv = mdl_b[i][k-1];
        end
      end
      exp_tx.push_back(txv);
      exp_busy.push_back((q.size() > 0) || (t < free));
      exp_full.push_back(q.size() == DEPTH);
      exp_ovf.push_back(ovf);
    end
  endtask

  // drive the schedule and tally per-signal disagreement with the model
  task automatic run_sched(output int bt, output int bb, output int bf, output int bo);
    bt = 0; bb = 0; bf = 0; bo = 0;
    obs_tx.delete(); obs_busy.delete(); obs_full.delete(); obs_ovf.delete();
    build_model(s_dat.size());
    for (int c = 0; c < s_dat.size(); c++) begin
      port_data = s_dat[c];
      port_wr   = s_wr[c];
      @(posedge clk); #1;
      obs_tx.push_back(tx); obs_busy.push_back(busy);
      obs_full.push_back(fifo_full); obs_ovf.push_back(overflow);
      if (tx !== exp_tx[c])          bt++;
      if (busy !== exp_busy[c])      bb++;
      if (fifo_full !== exp_full[c]) bf++;
      if (overflow !== exp_ovf[c])   bo++;
    end
    port_wr = 1'b0;
  endtask

  // simple UART receiver over the observed tx trace
  task automatic decode();
    int c;
    logic [7:0] b;
    c = 0;
    dec_b.delete(); dec_s.delete();
    while (c < obs_tx.size()) begin
      if (obs_tx[c] === 1'b0 && c + FRAME <= obs_tx.size()) begin
        for (int i = 0; i < 8; i++) b[i] = obs_tx[c + CPB*(i+1) + CPB/2];
        dec_b.push_back(b);
        dec_s.push_back(c);
        c += FRAME;
      end else begin
        c++;
      end
    end
  endtask

  task automatic test_reset();
    int bt, bb, bf, bo;
    port_wr = 1'b0; port_data = 8'h00;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx, busy, fifo_full, overflow} !== 4'b1000) begin
      failures++; $display("FAIL reset_state got=%b required=1000", {tx, busy, fifo_full, overflow});
    end
    checks++;
    if ({d_tx, d_busy, d_full, d_ovf} !== 4'b1000) begin
      failures++; $display("FAIL reset_state_def got=%b required=1000", {d_tx, d_busy, d_full, d_ovf});
    end
    @(negedge clk); rst_n = 1'b1;
    sched_idle(60, 8'h00);
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt + bb + bf + bo !== 0) begin
      failures++; $display("FAIL reset_idle mismatched_cycles=%0d required=0", bt + bb + bf + bo);
    end
  endtask

  task automatic test_single_frame();
    int bt, bb, bf, bo, bad;
    logic lv[10];
    lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    sched_idle(130, 8'h00);
    sched_write(2, 8'hA5);
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt !== 0) begin failures++; $display("FAIL single_tx_model mismatched_cycles=%0d required=0", bt); end
    checks++;
    if (bb + bf + bo !== 0) begin failures++; $display("FAIL single_flags_model mismatched_cycles=%0d required=0", bb + bf + bo); end
    checks++;
    if ({obs_tx[2], obs_tx[3]} !== 2'b10) begin
      failures++; $display("FAIL single_latency tx_after_k,k+1=%b required=10", {obs_tx[2], obs_tx[3]});
    end
    bad = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++)
        if (obs_tx[3 + CPB*i + j] !== lv[i]) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL single_a5_levels bad_cycles=%0d required=0", bad); end
    checks++;
    if ({obs_busy[102], obs_busy[103]} !== 2'b10) begin
      failures++; $display("FAIL single_busy_fall busy@+99,+100=%b required=10", {obs_busy[102], obs_busy[103]});
    end
  endtask

  task automatic test_overflow_burst();
    int bt, bb, bf, bo, bad;
    do_reset();
    sched_idle(540, 8'h00);
    for (int i = 0; i < 6; i++) sched_write(2 + i, 8'h10 + 8'(i));
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt + bb + bf + bo !== 0) begin
      failures++; $display("FAIL burst_model tx=%0d busy=%0d full=%0d ovf=%0d required=0", bt, bb, bf, bo);
    end
    checks++;
    if ({obs_full[5], obs_full[6]} !== 2'b01) begin
      failures++; $display("FAIL burst_full_after_5th got=%b required=01", {obs_full[5], obs_full[6]});
    end
    checks++;
    if ({obs_ovf[6], obs_ovf[7], obs_ovf[539]} !== 3'b011) begin
      failures++; $display("FAIL burst_overflow_sticky got=%b required=011", {obs_ovf[6], obs_ovf[7], obs_ovf[539]});
    end
    decode();
    checks++;
    if (dec_b.size() !== 5) begin failures++; $display("FAIL burst_frame_count got=%0d required=5", dec_b.size()); end
    bad = 0;
    for (int i = 0; i < dec_b.size(); i++)
      if (dec_b[i] !== 8'h10 + 8'(i) || dec_s[i] !== 3 + FRAME*i) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL burst_contiguous_order bad_frames=%0d required=0", bad); end
  endtask

  task automatic test_reset_mid_frame();
    int bt, bb, bf, bo;
    do_reset();
    sched_idle(47, 8'h00);
    sched_write(2, 8'h5A);
    sched_write(3, 8'h11);
    sched_write(4, 8'h22);
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt + bb + bf + bo !== 0) begin
      failures++; $display("FAIL midreset_pre_model mismatched_cycles=%0d required=0", bt + bb + bf + bo);
    end
    port_data = 8'h00;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, fifo_full} !== 3'b100) begin
      failures++; $display("FAIL midreset_immediate tx,busy,full=%b required=100", {tx, busy, fifo_full});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    sched_idle(400, 8'h00);
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt + bb + bf + bo !== 0) begin
      failures++; $display("FAIL midreset_post_model mismatched_cycles=%0d required=0", bt + bb + bf + bo);
    end
    decode();
    checks++;
    if (dec_b.size() !== 0) begin failures++; $display("FAIL midreset_no_frames got=%0d required=0", dec_b.size()); end
  endtask

  task automatic test_random();
    int bt, bb, bf, bo, c, nb, bad;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      sched_idle(2 + 7*31 + 6*FRAME + 20, 8'h00);
      nb = $urandom_range(2, 7);
      c = 2;
      for (int i = 0; i < nb; i++) begin
        sched_write(c, 8'($urandom));
        c += $urandom_range(1, 31);
      end
      run_sched(bt, bb, bf, bo);
      checks++;
      if (bt + bb + bf + bo !== 0) begin
        failures++; $display("FAIL random_model round=%0d tx=%0d busy=%0d full=%0d ovf=%0d required=0", r, bt, bb, bf, bo);
      end
      decode();
      bad = (dec_b.size() == mdl_b.size()) ? 0 : 1;
      for (int i = 0; i < dec_b.size() && i < mdl_b.size(); i++)
        if (dec_b[i] !== mdl_b[i]) bad++;
      checks++;
      if (bad !== 0) begin
        failures++; $display("FAIL random_bytes round=%0d frames=%0d required_frames=%0d bad=%0d", r, dec_b.size(), mdl_b.size(), bad);
      end
    end
  endtask

`ifdef CHANGE_DETECT_EN
  task automatic test_change_detect();
    int bt, bb, bf, bo;
    logic [15:0] got;
    do_reset();
    sched_idle(602, 8'h00);
    sched_write(2, 8'h3C);
    sched_write(302, 8'h00);
    for (int i = 0; i < 602; i++) s_wr[i] = 1'($urandom_range(0, 1));
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt + bb + bf + bo !== 0) begin
      failures++; $display("FAIL change_model mismatched_cycles=%0d required=0", bt + bb + bf + bo);
    end
    decode();
    checks++;
    if (dec_b.size() !== 2) begin failures++; $display("FAIL change_frame_count got=%0d required=2", dec_b.size()); end
    got = (dec_b.size() >= 2) ? {dec_b[0], dec_b[1]} : 16'hxxxx;
    checks++;
    if (got !== 16'h3C00) begin failures++; $display("FAIL change_bytes got=%h required=3c00", got); end
  endtask
`else
  task automatic test_data_without_strobe();
    int bt, bb, bf, bo;
    do_reset();
    sched_idle(200, 8'h00);
    for (int i = 2; i < 200; i += 7) s_dat[i] = 8'($urandom);
    run_sched(bt, bb, bf, bo);
    checks++;
    if (bt + bb + bf + bo !== 0) begin
      failures++; $display("FAIL nostrobe_model mismatched_cycles=%0d required=0", bt + bb + bf + bo);
    end
    decode();
    checks++;
    if (dec_b.size() !== 0) begin failures++; $display("FAIL nostrobe_frames got=%0d required=0", dec_b.size()); end
  endtask
`endif

  task automatic test_default_params();
    int w, lo, total;
    do_reset();
    d_data = 8'hFF;
    d_wr   = 1'b1;
    @(posedge clk); #1;
    d_wr = 1'b0;
    w = 0;
    while (d_tx !== 1'b0 && w < 10) begin @(posedge clk); #1; w++; end
    checks++;
    if (w !== 1) begin failures++; $display("FAIL default_latency cycles=%0d required=1", w); end
    lo = 0;
    while (d_tx === 1'b0 && lo < 3000) begin @(posedge clk); #1; lo++; end
    checks++;
    if (lo !== DEF_CPB) begin failures++; $display("FAIL default_start_bit low_cycles=%0d required=%0d", lo, DEF_CPB); end
    total = lo;
    while (d_busy === 1'b1 && total < 5000) begin @(posedge clk); #1; total++; end
    checks++;
    if (total !== 10*DEF_CPB) begin failures++; $display("FAIL default_frame_len cycles=%0d required=%0d", total, 10*DEF_CPB); end
    checks++;
    if ({d_tx, d_full, d_ovf} !== 3'b100) begin
      failures++; $display("FAIL default_end_state tx,full,ovf=%b required=100", {d_tx, d_full, d_ovf});
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow_burst();
    test_reset_mid_frame();
    test_random();
`ifdef CHANGE_DETECT_EN
    test_change_detect();
`else
    test_data_without_strobe();
`endif
    test_default_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
